// File: rtl/led_scan_decoder.sv
// led_scan_decoder: reads back the bouncing-LED bus, tracks the lit position and
// direction, reports lock (all-ones) and flags steps that break the bounce sequence.
// Optional feature macro: LED_DEC_BOUNCE_STATS_EN enables the reversal counter
// (bounce_cnt); when undefined bounce_cnt is tied to zero.
module led_scan_decoder #(
    parameter int WIDTH   = 10,
    parameter int MAX_POS = 7,
    parameter int ERR_CW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  led_in,
    input  logic              sample_en,
    output logic [3:0]        pos,
    output logic              dir,
    output logic              trk_valid,
    output logic              locked,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic [ERR_CW-1:0] err_count,
    output logic [15:0]       bounce_cnt
);

    localparam int         CW    = $clog2(WIDTH + 1);
    localparam logic [3:0] MAX_P = 4'(MAX_POS);

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_ILLEGAL = 2'd1;
    localparam logic [1:0] E_SEQ     = 2'd2;
    localparam logic [1:0] E_STALL   = 2'd3;

    typedef enum logic [1:0] {SYNC, ACQ, TRACK, LOCK} state_t;

    state_t            state, state_n;
    logic [3:0]        anchor, anchor_n;
    logic [3:0]        pos_n;
    logic              dir_n;
    logic              err_pulse_n;
    logic [1:0]        err_code_n;
    logic [ERR_CW-1:0] err_count_n;

    logic [CW-1:0]     ones;
    logic [3:0]        idx;
    logic              all_one;
    logic              one_hot;
    logic [3:0]        exp_pos;
    logic              exp_dir;
    logic              err_hit;
    logic [1:0]        err_kind;

    // Classify the bus: count set bits and remember the index of the (last) set bit.
    always_comb begin
        ones = '0;
        idx  = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (led_in[i]) begin
                ones = ones + CW'(1);
                idx  = 4'(i);
            end
        end
    end

    assign all_one = &led_in;
    assign one_hot = (ones == CW'(1)) && (idx <= MAX_P);

    // Next position of the bounce from the current (pos, dir); the turnaround
    // step already carries the new direction.
    always_comb begin
        exp_pos = pos;
        exp_dir = dir;
        if (!dir) begin
            if (pos < MAX_P) begin
                exp_pos = pos + 4'd1;
                exp_dir = 1'b0;
            end else begin
                exp_pos = MAX_P - 4'd1;
                exp_dir = 1'b1;
            end
        end else begin
            if (pos > 4'd0) begin
                exp_pos = pos - 4'd1;
                exp_dir = 1'b1;
            end else begin
                exp_pos = 4'd1;
                exp_dir = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; everything holds unless strobed,
    // except err_pulse which drops back to zero.
    always_comb begin
        state_n     = state;
        anchor_n    = anchor;
        pos_n       = pos;
        dir_n       = dir;
        err_pulse_n = 1'b0;
        err_code_n  = err_code;
        err_count_n = err_count;
        err_hit     = 1'b0;
        err_kind    = E_NONE;
        if (sample_en) begin
            if (all_one) begin
                state_n = LOCK;
            end else begin
                unique case (state)
                    SYNC: begin
                        if (one_hot) begin
                            anchor_n = idx;
                            state_n  = ACQ;
                        end
                    end
                    ACQ: begin
                        // Two adjacent one-hot samples establish position and direction.
                        if (!one_hot) begin
                            state_n = SYNC;
                        end else if (idx == anchor + 4'd1) begin
                            pos_n   = idx;
                            dir_n   = 1'b0;
                            state_n = TRACK;
                        end else if (anchor != 4'd0 && idx == anchor - 4'd1) begin
                            pos_n   = idx;
                            dir_n   = 1'b1;
                            state_n = TRACK;
                        end else begin
                            anchor_n = idx;
                        end
                    end
                    TRACK: begin
                        if (!one_hot) begin
                            err_hit  = 1'b1;
                            err_kind = E_ILLEGAL;
                        end else if (idx == exp_pos) begin
                            pos_n = idx;
                            dir_n = exp_dir;
                        end else if (idx == pos) begin
                            err_hit  = 1'b1;
                            err_kind = E_STALL;
                        end else begin
                            err_hit  = 1'b1;
                            err_kind = E_SEQ;
                        end
                    end
                    LOCK: begin
                        // Leaving lock produces transitional patterns; never an error.
                        state_n = SYNC;
                    end
                    default: state_n = SYNC;
                endcase
            end
            if (err_hit) begin
                err_pulse_n = 1'b1;
                err_code_n  = err_kind;
                if (err_count != '1)
                    err_count_n = err_count + ERR_CW'(1);
                state_n = SYNC;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SYNC;
            anchor    <= 4'd0;
            pos       <= 4'd0;
            dir       <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= E_NONE;
            err_count <= '0;
        end else begin
            state     <= state_n;
            anchor    <= anchor_n;
            pos       <= pos_n;
            dir       <= dir_n;
            err_pulse <= err_pulse_n;
            err_code  <= err_code_n;
            err_count <= err_count_n;
        end
    end

    assign trk_valid = (state == TRACK);
    assign locked    = (state == LOCK);

`ifdef LED_DEC_BOUNCE_STATS_EN
    logic bounce_step;

    // A reversal is the legal tracked step from the top position back down.
    assign bounce_step = sample_en && (state == TRACK) && one_hot && !dir &&
                         (pos == MAX_P) && (idx == MAX_P - 4'd1);

    // Reversal counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n)
            bounce_cnt <= 16'd0;
        else if (bounce_step)
            bounce_cnt <= bounce_cnt + 16'd1;
    end
`else
    assign bounce_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed-vector bench for led_scan_decoder.
module tb_led_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [9:0]  led_in;
    logic        sample_en;
    logic [3:0]  pos;
    logic        dir;
    logic        trk_valid;
    logic        locked;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic [15:0] bounce_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LED_DEC_BOUNCE_STATS_EN
    localparam logic [15:0] EXP_BOUNCE = 16'd1;
`else
    localparam logic [15:0] EXP_BOUNCE = 16'd0;
`endif

    led_scan_decoder #(.WIDTH(10), .MAX_POS(7), .ERR_CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .led_in(led_in), .sample_en(sample_en),
        .pos(pos), .dir(dir), .trk_valid(trk_valid), .locked(locked),
        .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count),
        .bounce_cnt(bounce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic strobe(input logic [9:0] v);
        led_in    = v;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        led_in    = 10'h000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; sample_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        led_in = 10'h000; sample_en = 1'b0; rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        n_cmp++; if (pos !== 4'd0 || dir !== 1'b0) begin n_bad++; $display("FAIL reset_posdir got=%0d/%0d want=0/0", pos, dir); end
        n_cmp++; if (trk_valid !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("FAIL reset_flags got=%0b/%0b want=0/0", trk_valid, locked); end
        n_cmp++; if (err_pulse !== 1'b0 || err_code !== 2'd0 || err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err got=%0b/%0d/%0d want=0/0/0", err_pulse, err_code, err_count); end
        n_cmp++; if (bounce_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_bounce got=%0d want=0", bounce_cnt); end
    endtask

    task automatic test_acquire;
        strobe(10'h001);
        n_cmp++; if (trk_valid !== 1'b0) begin n_bad++; $display("FAIL acq_first got=%0b want=0", trk_valid); end
        strobe(10'h002);
        n_cmp++; if (trk_valid !== 1'b1 || pos !== 4'd1 || dir !== 1'b0) begin n_bad++; $display("FAIL acq_second got=%0b/%0d/%0d want=1/1/0", trk_valid, pos, dir); end
        strobe(10'h004);
        n_cmp++; if (pos !== 4'd2 || dir !== 1'b0 || err_count !== 8'd0) begin n_bad++; $display("FAIL acq_third got=%0d/%0d/%0d want=2/0/0", pos, dir, err_count); end
    endtask

    task automatic test_bounce;
        strobe(10'h008); strobe(10'h010); strobe(10'h020); strobe(10'h040); strobe(10'h080);
        n_cmp++; if (pos !== 4'd7 || dir !== 1'b0) begin n_bad++; $display("FAIL bnc_top got=%0d/%0d want=7/0", pos, dir); end
        strobe(10'h040);
        n_cmp++; if (pos !== 4'd6 || dir !== 1'b1) begin n_bad++; $display("FAIL bnc_turn got=%0d/%0d want=6/1", pos, dir); end
        n_cmp++; if (bounce_cnt !== EXP_BOUNCE) begin n_bad++; $display("FAIL bnc_cnt got=%0d want=%0d", bounce_cnt, EXP_BOUNCE); end
        strobe(10'h020); strobe(10'h010); strobe(10'h008); strobe(10'h004); strobe(10'h002); strobe(10'h001);
        n_cmp++; if (pos !== 4'd0 || dir !== 1'b1) begin n_bad++; $display("FAIL bnc_bottom got=%0d/%0d want=0/1", pos, dir); end
        strobe(10'h002);
        n_cmp++; if (pos !== 4'd1 || dir !== 1'b0 || trk_valid !== 1'b1) begin n_bad++; $display("FAIL bnc_up got=%0d/%0d/%0b want=1/0/1", pos, dir, trk_valid); end
        n_cmp++; if (bounce_cnt !== EXP_BOUNCE || err_count !== 8'd0) begin n_bad++; $display("FAIL bnc_after got=%0d/%0d want=%0d/0", bounce_cnt, err_count, EXP_BOUNCE); end
    endtask

    task automatic test_hold;
        led_in = 10'h3FF; sample_en = 1'b0;
        idle(2);
        n_cmp++; if (pos !== 4'd1 || trk_valid !== 1'b1 || locked !== 1'b0) begin n_bad++; $display("FAIL hold got=%0d/%0b/%0b want=1/1/0", pos, trk_valid, locked); end
        led_in = 10'h000;
    endtask

    task automatic test_seq_err;
        do_reset;
        strobe(10'h001); strobe(10'h002); strobe(10'h004); strobe(10'h008);
        n_cmp++; if (pos !== 4'd3 || dir !== 1'b0 || trk_valid !== 1'b1) begin n_bad++; $display("FAIL seq_pre got=%0d/%0d/%0b want=3/0/1", pos, dir, trk_valid); end
        strobe(10'h020);
        n_cmp++; if (err_pulse !== 1'b1 || err_code !== 2'd2 || err_count !== 8'd1 || trk_valid !== 1'b0) begin n_bad++; $display("FAIL seq_err got=%0b/%0d/%0d/%0b want=1/2/1/0", err_pulse, err_code, err_count, trk_valid); end
        idle(1);
        n_cmp++; if (err_pulse !== 1'b0 || err_code !== 2'd2 || pos !== 4'd3) begin n_bad++; $display("FAIL seq_after got=%0b/%0d/%0d want=0/2/3", err_pulse, err_code, pos); end
    endtask

    task automatic test_stall_illegal;
        strobe(10'h001); strobe(10'h002); strobe(10'h002);
        n_cmp++; if (err_pulse !== 1'b1 || err_code !== 2'd3 || err_count !== 8'd2) begin n_bad++; $display("FAIL stall got=%0b/%0d/%0d want=1/3/2", err_pulse, err_code, err_count); end
        strobe(10'h001); strobe(10'h002); strobe(10'h003);
        n_cmp++; if (err_code !== 2'd1 || err_count !== 8'd3 || trk_valid !== 1'b0) begin n_bad++; $display("FAIL illegal got=%0d/%0d/%0b want=1/3/0", err_code, err_count, trk_valid); end
        strobe(10'h001); strobe(10'h002); strobe(10'h200);
        n_cmp++; if (err_code !== 2'd1 || err_count !== 8'd4 || err_pulse !== 1'b1) begin n_bad++; $display("FAIL illegal_high got=%0d/%0d/%0b want=1/4/1", err_code, err_count, err_pulse); end
    endtask

    task automatic test_acq_rules;
        strobe(10'h100);
        n_cmp++; if (err_pulse !== 1'b0 || err_count !== 8'd4 || trk_valid !== 1'b0) begin n_bad++; $display("FAIL sync_illegal got=%0b/%0d/%0b want=0/4/0", err_pulse, err_count, trk_valid); end
        strobe(10'h010); strobe(10'h040); strobe(10'h000);
        n_cmp++; if (err_pulse !== 1'b0 || err_count !== 8'd4 || trk_valid !== 1'b0) begin n_bad++; $display("FAIL acq_drop got=%0b/%0d/%0b want=0/4/0", err_pulse, err_count, trk_valid); end
        strobe(10'h040); strobe(10'h020);
        n_cmp++; if (pos !== 4'd5 || dir !== 1'b1 || trk_valid !== 1'b1) begin n_bad++; $display("FAIL acq_down got=%0d/%0d/%0b want=5/1/1", pos, dir, trk_valid); end
        strobe(10'h010); strobe(10'h008);
        n_cmp++; if (pos !== 4'd3 || dir !== 1'b1) begin n_bad++; $display("FAIL trk_down got=%0d/%0d want=3/1", pos, dir); end
    endtask

    task automatic test_lock;
        for (int i = 0; i < 3; i++) begin
            strobe(10'h3FF);
            n_cmp++; if (locked !== 1'b1 || trk_valid !== 1'b0 || err_pulse !== 1'b0) begin n_bad++; $display("FAIL lock_%0d got=%0b/%0b/%0b want=1/0/0", i, locked, trk_valid, err_pulse); end
        end
        strobe(10'h1FF);
        n_cmp++; if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd4) begin n_bad++; $display("FAIL lock_exit got=%0b/%0b/%0d want=0/0/4", locked, err_pulse, err_count); end
        strobe(10'h001); strobe(10'h002);
        n_cmp++; if (trk_valid !== 1'b1 || pos !== 4'd1 || dir !== 1'b0) begin n_bad++; $display("FAIL lock_retrack got=%0b/%0d/%0d want=1/1/0", trk_valid, pos, dir); end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0; led_in = 10'h004; sample_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; sample_en = 1'b0; led_in = 10'h000;
        n_cmp++; if (pos !== 4'd0 || dir !== 1'b0 || trk_valid !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_state got=%0d/%0d/%0b/%0b want=0/0/0/0", pos, dir, trk_valid, locked); end
        n_cmp++; if (err_pulse !== 1'b0 || err_code !== 2'd0 || err_count !== 8'd0 || bounce_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_err got=%0b/%0d/%0d/%0d want=0/0/0/0", err_pulse, err_code, err_count, bounce_cnt); end
        strobe(10'h004);
        n_cmp++; if (trk_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_sync got=%0b want=0", trk_valid); end
    endtask

    task automatic test_saturate;
        do_reset;
        for (int i = 0; i < 255; i++) begin
            strobe(10'h001); strobe(10'h002); strobe(10'h002);
        end
        n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_255 got=%0d want=255", err_count); end
        strobe(10'h001); strobe(10'h002); strobe(10'h002);
        n_cmp++; if (err_count !== 8'd255 || err_pulse !== 1'b1 || err_code !== 2'd3) begin n_bad++; $display("FAIL sat_256 got=%0d/%0b/%0d want=255/1/3", err_count, err_pulse, err_code); end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; led_in = 10'h000;
        test_reset;
        test_acquire;
        test_bounce;
        test_hold;
        test_seq_err;
        test_stall_illegal;
        test_acq_rules;
        test_lock;
        test_reset_mid;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
